// File: rtl/conv_ofm_writer_pkg.sv
// rtl/conv_ofm_writer_pkg.sv - shared layer-controller state encoding and width helper
package conv_ofm_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } layer_state_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_ofm_writer_addr_gen.sv
// rtl/conv_ofm_writer_addr_gen.sv - col/row/filter counters and incremental padded write address
module padded_addr_gen
  import conv_ofm_writer_pkg::*;
#(
  parameter int OFM_SIZE          = 30,
  parameter int PAD               = 2,
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int NEXT_IFM_SIZE     = OFM_SIZE + 2 * PAD,
  parameter int ADDRESS_SIZE_NEXT = $clog2(NEXT_IFM_SIZE * NEXT_IFM_SIZE),
  parameter int FILT_W            = cnt_width(NUMBER_OF_FILTERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_init,
  input  logic                         i_advance,
  output logic [ADDRESS_SIZE_NEXT-1:0] o_addr,
  output logic [FILT_W-1:0]            o_filt,
  output logic                         o_last
);

  localparam int POS_W = cnt_width(OFM_SIZE);
  localparam logic [POS_W-1:0]             POS_LAST   = POS_W'(OFM_SIZE - 1);
  localparam logic [FILT_W-1:0]            FILT_LAST  = FILT_W'(NUMBER_OF_FILTERS - 1);
  localparam logic [ADDRESS_SIZE_NEXT-1:0] ADDR_FIRST = ADDRESS_SIZE_NEXT'(PAD * NEXT_IFM_SIZE + PAD);
  localparam logic [ADDRESS_SIZE_NEXT-1:0] ROW_STEP   = ADDRESS_SIZE_NEXT'(2 * PAD + 1);

  logic [POS_W-1:0]             r_col;
  logic [POS_W-1:0]             r_row;
  logic [FILT_W-1:0]            r_filt;
  logic [ADDRESS_SIZE_NEXT-1:0] r_addr;
  logic                         w_col_wrap;
  logic                         w_row_wrap;

  assign w_col_wrap = (r_col == POS_LAST);
  assign w_row_wrap = w_col_wrap && (r_row == POS_LAST);

  // Row step skips the right border of this row and the left border of the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_filt <= '0;
      r_addr <= '0;
    end else if (i_init) begin
      r_col  <= '0;
      r_row  <= '0;
      r_filt <= '0;
      r_addr <= ADDR_FIRST;
    end else if (i_advance) begin
      if (w_row_wrap) begin
        r_col  <= '0;
        r_row  <= '0;
        r_filt <= (r_filt == FILT_LAST) ? '0 : r_filt + 1'b1;
        r_addr <= ADDR_FIRST;
      end else if (w_col_wrap) begin
        r_col  <= '0;
        r_row  <= r_row + 1'b1;
        r_addr <= r_addr + ROW_STEP;
      end else begin
        r_col  <= r_col + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_filt = r_filt;
  assign o_last = (r_filt == FILT_LAST) && w_row_wrap;

endmodule

// File: rtl/conv_ofm_writer.sv
// rtl/conv_ofm_writer.sv - turns the post-ReLU pixel stream into padded next-layer IFM writes
module conv_ofm_writer
  import conv_ofm_writer_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int OFM_SIZE          = 30,
  parameter int PAD               = 2,
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int CLEAR_EN          = 1,
  parameter int NEXT_IFM_SIZE     = OFM_SIZE + 2 * PAD,
  parameter int ADDRESS_SIZE_NEXT = $clog2(NEXT_IFM_SIZE * NEXT_IFM_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         data_valid,
  output logic                         ready,
  output logic [DATA_WIDTH-1:0]        wr_data,
  output logic [ADDRESS_SIZE_NEXT-1:0] wr_address,
  output logic [NUMBER_OF_FILTERS-1:0] wr_enable,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int FILT_W = cnt_width(NUMBER_OF_FILTERS);
  localparam logic [ADDRESS_SIZE_NEXT-1:0] CLR_LAST =
    ADDRESS_SIZE_NEXT'(NEXT_IFM_SIZE * NEXT_IFM_SIZE - 1);

  layer_state_t                 r_state;
  layer_state_t                 w_next_state;
  logic [ADDRESS_SIZE_NEXT-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0]        r_wr_data;
  logic [ADDRESS_SIZE_NEXT-1:0] r_wr_address;
  logic [NUMBER_OF_FILTERS-1:0] r_wr_enable;
  logic                         r_done;
  logic                         r_err;

  logic                         w_start;
  logic                         w_accept;
  logic                         w_overrun;
  logic                         w_clr_last;
  logic                         w_in_clear;
  logic [ADDRESS_SIZE_NEXT-1:0] w_gen_addr;
  logic [FILT_W-1:0]            w_gen_filt;
  logic                         w_gen_last;
  logic [NUMBER_OF_FILTERS-1:0] w_onehot;

  assign w_start    = start && (r_state == ST_IDLE);
  assign w_accept   = data_valid && (r_state == ST_RUN);
  assign w_overrun  = data_valid && (r_state != ST_RUN);
  assign w_clr_last = (r_clr_cnt == CLR_LAST);
  assign w_in_clear = (r_state == ST_CLEAR);

  padded_addr_gen #(
    .OFM_SIZE          (OFM_SIZE),
    .PAD               (PAD),
    .NUMBER_OF_FILTERS (NUMBER_OF_FILTERS),
    .NEXT_IFM_SIZE     (NEXT_IFM_SIZE),
    .ADDRESS_SIZE_NEXT (ADDRESS_SIZE_NEXT),
    .FILT_W            (FILT_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_init    (w_start),
    .i_advance (w_accept),
    .o_addr    (w_gen_addr),
    .o_filt    (w_gen_filt),
    .o_last    (w_gen_last)
  );

  always_comb begin
    w_onehot = '0;
    w_onehot[w_gen_filt] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
      ST_CLEAR: if (w_clr_last) w_next_state = ST_RUN;
      ST_RUN:   if (w_accept && w_gen_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_cnt <= '0;
    end else if (w_start) begin
      r_clr_cnt <= '0;
    end else if (w_in_clear) begin
      r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
    end
  end

  // Clear writes are shadowed into the hold registers so the bus holds its last value afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_data    <= '0;
      r_wr_address <= '0;
      r_wr_enable  <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_overrun)    r_err <= 1'b1;
      else if (w_start) r_err <= 1'b0;
      if (w_in_clear) begin
        r_wr_data    <= '0;
        r_wr_address <= r_clr_cnt;
        r_wr_enable  <= '0;
      end else if (w_accept) begin
        r_wr_data    <= data_in;
        r_wr_address <= w_gen_addr;
        r_wr_enable  <= w_onehot;
      end else begin
        r_wr_enable  <= '0;
      end
    end
  end

  assign wr_enable  = w_in_clear ? '1 : r_wr_enable;
  assign wr_address = w_in_clear ? r_clr_cnt : r_wr_address;
  assign wr_data    = w_in_clear ? '0 : r_wr_data;
  assign ready      = (r_state == ST_RUN);
  assign busy       = (r_state == ST_CLEAR) || (r_state == ST_RUN);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_conv_ofm_writer.sv
// tb/tb_conv_ofm_writer.sv - directed table-driven bench for conv_ofm_writer (4x4 OFM, pad 1, 2 filters)
module tb_conv_ofm_writer;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NF = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          ready;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_address;
  logic [NF-1:0] wr_enable;
  logic          busy;
  logic          done;
  logic          err;

  conv_ofm_writer #(
    .DATA_WIDTH        (DW),
    .OFM_SIZE          (4),
    .PAD               (1),
    .NUMBER_OF_FILTERS (NF),
    .CLEAR_EN          (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .wr_data    (wr_data),
    .wr_address (wr_address),
    .wr_enable  (wr_enable),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic [31:0] din;
    logic [5:0]  addr;
    logic [1:0]  en;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference mapping written in closed form: filter-major, then row, then col.
  function automatic logic [5:0] ref_addr(input int i);
    int r, c;
    r = (i % 16) / 4;
    c = i % 4;
    return 6'((r + 1) * 6 + c + 1);
  endfunction

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(name, {63'd0, ready}, 64'd1);
  endtask

  initial begin
    int strobes;
    logic [5:0] prev_addr;
    logic [31:0] d;

    vecs[0] = '{0,  32'h11,       6'd7,  2'b01};
    vecs[1] = '{1,  32'h22,       6'd8,  2'b01};
    vecs[2] = '{3,  32'h33,       6'd10, 2'b01};
    vecs[3] = '{4,  32'h44,       6'd13, 2'b01};
    vecs[4] = '{15, 32'h55,       6'd28, 2'b01};
    vecs[5] = '{16, 32'h66,       6'd7,  2'b10};
    vecs[6] = '{31, 32'hDEADBEEF, 6'd28, 2'b10};

    reset = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = '0;

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset_wr_enable", 64'(wr_enable), 64'd0);
      chk("reset_wr_address", 64'(wr_address), 64'd0);
      chk("reset_wr_data", 64'(wr_data), 64'd0);
      chk("reset_flags", {60'd0, ready, busy, done, err}, 64'd0);
      start = 1'($urandom); data_valid = 1'($urandom); data_in = $urandom;
    end
    start = 1'b0; data_valid = 1'b0; data_in = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_flags", {60'd0, ready, busy, done, err}, 64'd0);

    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("idle_overrun_err", {63'd0, err}, 64'd1);
    chk("idle_overrun_no_write", 64'(wr_enable), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clears_err", {63'd0, err}, 64'd0);

    for (int k = 0; k < 36; k++) begin
      chk("clear_addr", 64'(wr_address), 64'(k));
      chk("clear_en", 64'(wr_enable), 64'd3);
      chk("clear_data", 64'(wr_data), 64'd0);
      chk("clear_busy_ready", {62'd0, busy, ready}, 64'd2);
      @(negedge clk);
    end
    chk("run_ready", {63'd0, ready}, 64'd1);
    chk("run_idle_en", 64'(wr_enable), 64'd0);

    strobes = 0;
    prev_addr = '0;
    for (int i = 0; i < 32; i++) begin
      if (i % 3 == 1) begin
        @(negedge clk);
        chk("gap_no_write", 64'(wr_enable), 64'd0);
        chk("gap_addr_hold", 64'(wr_address), 64'(prev_addr));
      end
      d = 32'h1000 + 32'(i);
      for (int v = 0; v < 7; v++) if (vecs[v].idx == i) d = vecs[v].din;
      data_valid = 1'b1;
      data_in = d;
      @(negedge clk);
      data_valid = 1'b0;
      if (wr_enable != 0) strobes++;
      chk("px_addr", 64'(wr_address), 64'(ref_addr(i)));
      chk("px_en", 64'(wr_enable), (i < 16) ? 64'd1 : 64'd2);
      chk("px_data", 64'(wr_data), 64'(d));
      for (int v = 0; v < 7; v++) begin
        if (vecs[v].idx == i) begin
          chk("vec_addr", 64'(wr_address), 64'(vecs[v].addr));
          chk("vec_en", 64'(wr_enable), 64'(vecs[v].en));
        end
      end
      prev_addr = wr_address;
    end
    chk("last_write_done_low", {62'd0, done, busy}, 64'd0);
    chk("strobe_count", 64'(strobes), 64'd32);
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("done_no_write", 64'(wr_enable), 64'd0);
    chk("done_busy_ready", {62'd0, busy, ready}, 64'd0);
    @(negedge clk);
    chk("after_done", {61'd0, done, busy, ready}, 64'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("clear_overrun_err", {63'd0, err}, 64'd1);
    chk("clear_overrun_en", 64'(wr_enable), 64'd3);
    chk("clear_overrun_addr", 64'(wr_address), 64'd1);
    wait_ready("ready_after_clear2");
    chk("err_sticky_run", {63'd0, err}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      data_valid = 1'b1;
      data_in = 32'h2000 + 32'(i);
      @(negedge clk);
      data_valid = 1'b0;
      chk("px2_addr", 64'(wr_address), 64'(ref_addr(i)));
    end
    chk("px10_en", 64'(wr_enable), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_en", 64'(wr_enable), 64'd0);
    chk("abort_addr", 64'(wr_address), 64'd0);
    chk("abort_data", 64'(wr_data), 64'd0);
    chk("abort_flags", {60'd0, ready, busy, done, err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready("ready_after_restart");
    data_valid = 1'b1;
    data_in = 32'hABCD;
    @(negedge clk);
    data_valid = 1'b0;
    chk("restart_addr", 64'(wr_address), 64'd7);
    chk("restart_en", 64'(wr_enable), 64'd1);
    chk("restart_data", 64'(wr_data), 64'hABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ofm_writer.md
Name: conv_ofm_writer

Overview:
Consumer end of a conv datapath's output stream. Takes the post-ReLU pixel stream (data_out_for_next plus a valid strobe from the layer controller) and turns it into write-port traffic for the next layer's IFM memories. It generates the padded write address and a one-hot per-filter write enable. It can optionally zero-fill the next layer's memories first, so the padding border reads as zero.

Parameters:
DATA_WIDTH, 32, pixel word width
OFM_SIZE, 30, output feature map side length (pixels per row/column of one filter)
PAD, 2, zero border width in the next layer's IFM
NUMBER_OF_FILTERS, 8, number of output maps; also the number of next-layer IFM memories
CLEAR_EN, 1, 1 = zero-fill all next-layer memories after start; 0 = skip the fill
NEXT_IFM_SIZE, OFM_SIZE+2*PAD, derived: next-layer IFM side length
ADDRESS_SIZE_NEXT, $clog2(NEXT_IFM_SIZE*NEXT_IFM_SIZE), derived: write address width

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low; low forces the reset state immediately
start  input  1  one-cycle pulse; begins a layer pass
data_in  input  DATA_WIDTH  pixel from the conv datapath
data_valid  input  1  data_in is valid this cycle
ready  output  1  high only in RUN; the controller must not assert data_valid while ready is low
wr_data  output  DATA_WIDTH  next-layer IFM write data
wr_address  output  ADDRESS_SIZE_NEXT  next-layer IFM write address
wr_enable  output  NUMBER_OF_FILTERS  per-memory write enable; drives the next layer's ifm_enable_write_previous
busy  output  1  high in CLEAR and RUN
done  output  1  one-cycle pulse when a pass completes
err  output  1  sticky overrun flag; cleared by start or reset

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE -> CLEAR on start when CLEAR_EN=1; IDLE -> RUN on start when CLEAR_EN=0. start also clears err.
- start is ignored in any state other than IDLE.
- CLEAR: a clear counter runs 0 .. NEXT_IFM_SIZE^2-1, one address per cycle.
  - Each cycle writes wr_data=0, wr_address=counter, wr_enable=all ones.
  - After the last address the FSM goes to RUN; ready rises the following cycle.
- RUN: counters col (0..OFM_SIZE-1), row (0..OFM_SIZE-1) and filt (0..NUMBER_OF_FILTERS-1) advance only on an accepted data_valid.
  - Input order is filter-major, then row, then col.
  - col wraps to 0 and increments row. row wrap (with col wrap) clears row and increments filt.
- Write mapping, latency 1: the cycle after an accepted pixel, outputs are registered as:
  - wr_data = data_in
  - wr_address = (row+PAD)*NEXT_IFM_SIZE + col + PAD
  - wr_enable = one-hot bit filt
- In cycles with no accepted pixel, wr_enable = 0. wr_data and wr_address hold their last values.
- The address is maintained incrementally, with no multiplier:
  - +1 per pixel;
  - +2*PAD+1 at a row wrap;
  - reload PAD*NEXT_IFM_SIZE+PAD at a filter wrap.
- Last pixel (filt=N-1, row=col=OFM_SIZE-1): its write is issued normally, and the FSM goes to DONE in the same edge.
- DONE: lasts one cycle; done=1 and busy=0; then IDLE.
  - Net effect: done is high in the cycle after the final write strobe.
- data_valid while not in RUN: the pixel is dropped, no write occurs, err is set. err stays 1 until the next start or reset.
- Reset asserted mid-CLEAR or mid-RUN: outputs clear asynchronously. A partial pass is not resumed.
- Arithmetic: all counters unsigned. Data passes through unmodified; no arithmetic is applied to data_in.

Decomposition:
- Shared package: the FSM state enum (IDLE/CLEAR/RUN/DONE) and a clog2-derived width helper, reused by the layer controllers.
- Sub-module: padded_addr_gen, holding the row/col/filt counters, the incremental address and last-pixel detect.
- The FSM and the output registers stay in the top module.

Test Plan:
All scenarios use OFM_SIZE=4, PAD=1, NUMBER_OF_FILTERS=2 (NEXT_IFM_SIZE=6, 36 addresses) unless stated.
- Reset: hold reset=0 with random inputs -> all outputs 0, ready=0, busy=0.
- CLEAR_EN=1: pulse start -> 36 consecutive cycles with wr_enable=2'b11, wr_data=0, wr_address 0..35; busy=1 throughout; then ready=1.
- First pixel, data_in=0x11 -> next cycle wr_address=7, wr_enable=2'b01, wr_data=0x11.
- Wrap points: 5th pixel (row1,col0) -> address 13. 16th pixel -> address 28, wr_enable=2'b01. 17th pixel -> address 7, wr_enable=2'b10.
- Completion: stream 32 pixels with gaps in data_valid -> exactly 32 write strobes; done=1 for one cycle, one cycle after the 32nd write; then busy=0 and ready=0.
- Overrun and abort:
  - data_valid=1 during CLEAR -> no extra write, err=1 until the next start.
  - reset pulsed after pixel 10 -> outputs clear immediately; a new start restarts with address 7 for filter 0.
